// File: rtl/axi_rd_arbiter.sv
// AXI4 read-port concentrator: NUM_REQ requestors share one AXI read channel.
// Round-robin grant, one burst in flight, return beats routed by the granted
// index, sticky error flag for bad responses, ID mismatches and length errors.
module axi_rd_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ-1:0]            resp_last,
  output logic                          err,
  output logic [ID_WIDTH-1:0]           arid_m_inf,
  output logic [ADDR_WIDTH-1:0]         araddr_m_inf,
  output logic [LEN_WIDTH-1:0]          arlen_m_inf,
  output logic [2:0]                    arsize_m_inf,
  output logic [1:0]                    arburst_m_inf,
  output logic                          arvalid_m_inf,
  input  logic                          arready_m_inf,
  input  logic [ID_WIDTH-1:0]           rid_m_inf,
  input  logic [DATA_WIDTH-1:0]         rdata_m_inf,
  input  logic [1:0]                    rresp_m_inf,
  input  logic                          rlast_m_inf,
  input  logic                          rvalid_m_inf,
  output logic                          rready_m_inf
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr, gnt_idx, gnt_q, nxt_ptr;
  logic                 gnt_any;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 r_fire;

  assign arsize_m_inf  = 3'b001;
  assign arburst_m_inf = 2'b01;
  assign r_fire        = (state_q == R) && rvalid_m_inf;
  // Pointer moves just past the port that finished; wraps to 0 (constant 0 when NUM_REQ=1).
  assign nxt_ptr       = (32'(gnt_q) == 32'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  // Round-robin search starting at rr_ptr; descending loop so the nearest candidate wins.
  always_comb begin
    logic [PTR_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ));
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    arvalid_m_inf = 1'b0;
    rready_m_inf  = 1'b0;
    case (state_q)
      IDLE: if (gnt_any) begin
        req_ready[gnt_idx] = 1'b1;
        state_d            = AR;
      end
      AR: begin
        arvalid_m_inf = 1'b1;
        if (arready_m_inf) state_d = R;
      end
      R: begin
        rready_m_inf = 1'b1;
        if (rvalid_m_inf && rlast_m_inf) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request, count beats, advance the round-robin pointer on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_m_inf <= '0;
      arlen_m_inf  <= '0;
      arid_m_inf   <= '0;
      gnt_q        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
    end else begin
      if (state_q == IDLE && gnt_any) begin
        araddr_m_inf <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        arlen_m_inf  <= req_len[gnt_idx*LEN_WIDTH +: LEN_WIDTH];
        arid_m_inf   <= ID_WIDTH'(gnt_idx);
        gnt_q        <= gnt_idx;
        beat_cnt     <= '0;
      end
      if (r_fire) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (rlast_m_inf) rr_ptr <= nxt_ptr;
      end
    end
  end

  // Register each accepted beat onto the granted requestor's one-hot strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data  <= '0;
      resp_valid <= '0;
      resp_last  <= '0;
    end else begin
      resp_valid <= '0;
      resp_last  <= '0;
      if (r_fire) begin
        resp_data         <= rdata_m_inf;
        resp_valid[gnt_q] <= 1'b1;
        resp_last[gnt_q]  <= rlast_m_inf;
      end
    end
  end

  // Sticky error: bad rresp, wrong rid, or rlast not coinciding with the final counted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (r_fire && ((rresp_m_inf != 2'b00) || (rid_m_inf != arid_m_inf) ||
                        (rlast_m_inf != (beat_cnt == arlen_m_inf))))
      err <= 1'b1;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: requestor driver with a round-robin
// reference, a DRAM responder that predicts every returned beat, and a monitor
// that pops predictions whenever the DUT strobes resp_valid/resp_last.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid, req_ready;
  logic [63:0] req_addr;
  logic [13:0] req_len;
  logic [15:0] resp_data;
  logic [1:0]  resp_valid, resp_last;
  logic        err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [6:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [15:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_last(resp_last), .err(err),
    .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen), .arsize_m_inf(arsize),
    .arburst_m_inf(arburst), .arvalid_m_inf(arvalid), .arready_m_inf(arready),
    .rid_m_inf(rid), .rdata_m_inf(rdata), .rresp_m_inf(rresp), .rlast_m_inf(rlast),
    .rvalid_m_inf(rvalid), .rready_m_inf(rready)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  len;
    int          ardly;
    int          bad_resp;
    int          bad_rid;
    int          early;
    bit          seq;
    bit          gaps;
    bit          hold;
    logic [15:0] dbase;
    int          g;
  } cfg_t;

  typedef struct {
    int          g;
    logic [15:0] data;
    bit          last;
    bit          err;
  } rsp_t;

  cfg_t req_q[2][$];
  cfg_t ar_q[$];
  rsp_t resp_q[$];
  int   model_ptr = 0;
  bit   err_exp = 1'b0;
  bit   busy = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic cfg_t mk(input logic [31:0] a, input logic [6:0] l);
    cfg_t c;
    c.addr = a; c.len = l; c.ardly = 0; c.bad_resp = -1; c.bad_rid = -1; c.early = -1;
    c.seq = 1'b0; c.gaps = 1'b0; c.hold = 1'b0; c.dbase = 16'h0; c.g = 0;
    return c;
  endfunction

  // Requestor driver + round-robin reference: who should win given the pointer and requests.
  initial begin
    int   g;
    cfg_t c;
    logic [1:0] oh;
    req_valid = '0; req_addr = '0; req_len = '0;
    forever begin
      @(negedge clk);
      if (rst_n && req_ready != 2'b00) begin
        g = -1;
        for (int k = 1; k >= 0; k--) if (req_valid[(model_ptr + k) % 2]) g = (model_ptr + k) % 2;
        oh = (g < 0) ? 2'b00 : (2'b01 << g);
        chk("grant", 64'(req_ready), 64'(oh));
        if (g >= 0 && req_q[g].size() > 0) begin
          c = req_q[g].pop_front();
          c.g = g;
          ar_q.push_back(c);
          model_ptr = (g + 1) % 2;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = (req_q[i].size() != 0);
        if (req_q[i].size() != 0) begin
          req_addr[i*32 +: 32] = req_q[i][0].addr;
          req_len[i*7 +: 7]    = req_q[i][0].len;
        end
      end
    end
  end

  // DRAM responder: checks the AR phase, then returns beats and predicts each response.
  initial begin
    cfg_t c;
    int   nb;
    bit   lst;
    rsp_t r;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rid = '0; rresp = '0; rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (arvalid && rst_n) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 64'(arvalid), 64'(0));
        else begin
          c = ar_q.pop_front();
          busy = 1'b1;
          for (int d = 0; d < c.ardly; d++) begin
            chk("ar_hold_valid", 64'(arvalid), 64'(1));
            chk("ar_hold_addr", 64'(araddr), 64'(c.addr));
            chk("ar_hold_len", 64'(arlen), 64'(c.len));
            // Junk beats while not in R must be ignored entirely.
            rvalid = 1'($urandom_range(0, 1)); rresp = 2'b11; rlast = 1'b1; rid = 4'hF;
            rdata = 16'($urandom);
            @(negedge clk);
          end
          rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
          chk("arvalid", 64'(arvalid), 64'(1));
          chk("arid", 64'(arid), 64'(c.g));
          chk("araddr", 64'(araddr), 64'(c.addr));
          chk("arlen", 64'(arlen), 64'(c.len));
          chk("arsize", 64'(arsize), 64'(1));
          chk("arburst", 64'(arburst), 64'(1));
          arready = 1'b1;
          @(negedge clk);
          arready = 1'b0;
          chk("ar_single", 64'(arvalid), 64'(0));
          if (!c.hold) begin
            nb = (c.early >= 0) ? c.early + 1 : int'(c.len) + 1;
            for (int b = 0; b < nb; b++) begin
              if (c.gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
              lst    = (b == nb - 1);
              rvalid = 1'b1;
              rdata  = c.seq ? c.dbase + 16'(b) : 16'($urandom);
              rlast  = lst;
              rresp  = (b == c.bad_resp) ? 2'b10 : 2'b00;
              rid    = 4'(c.g) ^ ((b == c.bad_rid) ? 4'h8 : 4'h0);
              if (b == c.bad_resp || b == c.bad_rid || (lst != (b == int'(c.len)))) err_exp = 1'b1;
              r.g = c.g; r.data = rdata; r.last = lst; r.err = err_exp;
              resp_q.push_back(r);
              @(negedge clk);
              rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end
          end
          busy = 1'b0;
        end
      end
    end
  end

  // Response monitor: every strobe must match the next predicted beat.
  initial begin
    rsp_t e;
    logic [1:0] oh;
    forever begin
      @(negedge clk);
      if (resp_valid != 2'b00 || resp_last != 2'b00) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'(0));
        else begin
          e  = resp_q.pop_front();
          oh = 2'b01 << e.g;
          chk("resp_valid", 64'(resp_valid), 64'(oh));
          chk("resp_last", 64'(resp_last), e.last ? 64'(oh) : 64'(0));
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((req_q[0].size() != 0 || req_q[1].size() != 0 || ar_q.size() != 0 ||
            resp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n >= budget), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_q[0].delete(); req_q[1].delete(); ar_q.delete(); resp_q.delete();
    model_ptr = 0; err_exp = 1'b0;
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_rready", 64'(rready), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_last", 64'(resp_last), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_arid", 64'(arid), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("rst_arlen", 64'(arlen), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cfg_t c;
    int   n;
    do_reset();

    // Single 8-beat burst with known data.
    c = mk(32'h1000, 7); c.seq = 1'b1; c.dbase = 16'hA000;
    req_q[0].push_back(c);
    wait_idle(2000);

    // Both ports contending: strict alternation.
    for (int k = 0; k < 2; k++) begin
      req_q[0].push_back(mk(32'h2000 + 32'(k * 64), 3));
      req_q[1].push_back(mk(32'h3000 + 32'(k * 64), 3));
    end
    wait_idle(2000);

    // Slow arready: address phase must hold steady.
    c = mk(32'h4000, 5); c.ardly = 5;
    req_q[1].push_back(c);
    wait_idle(2000);

    // Single-beat burst with SLVERR, then a clean burst: err stays set.
    c = mk(32'h5000, 0); c.bad_resp = 0;
    req_q[0].push_back(c);
    wait_idle(2000);
    req_q[1].push_back(mk(32'h5100, 2));
    wait_idle(2000);
    chk("err_sticky", 64'(err), 64'(1));

    // Reset while in R: port 0 just finished, port 1 stuck mid-burst.
    req_q[0].push_back(mk(32'h6000, 1));
    wait_idle(2000);
    c = mk(32'h6100, 3); c.hold = 1'b1;
    req_q[1].push_back(c);
    n = 0;
    while (!rready && n < 100) begin @(negedge clk); n++; end
    chk("hold_in_r", 64'(rready), 64'(1));
    do_reset();
    req_q[0].push_back(mk(32'h6200, 1));
    req_q[1].push_back(mk(32'h6300, 1));
    wait_idle(2000);

    // Early rlast on beat 3 of 8, then a normal grant.
    c = mk(32'h7000, 7); c.early = 3;
    req_q[0].push_back(c);
    wait_idle(2000);
    req_q[1].push_back(mk(32'h7100, 2));
    wait_idle(2000);
    chk("err_early_last", 64'(err), 64'(1));

    // Wrong rid on one beat from a clean start.
    do_reset();
    c = mk(32'h8000, 3); c.bad_rid = 1;
    req_q[1].push_back(c);
    wait_idle(2000);

    // Random clean traffic in waves.
    do_reset();
    for (int w = 0; w < 6; w++) begin
      for (int j = 0; j < 4; j++) begin
        c = mk(32'($urandom), 7'($urandom_range(0, 7)));
        c.ardly = $urandom_range(0, 3); c.gaps = 1'b1;
        req_q[$urandom_range(0, 1)].push_back(c);
      end
      wait_idle(3000);
    end
    chk("err_clean", 64'(err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
